// File: rtl/full_hash_des.sv
// Byte-serial hash over a nibble chaining state mixed through DES S-box 1.
// Length-prefixed messages, digest registered one clock after the last byte.
module full_hash_des (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [63:0] C_in,
  input  logic [7:0]  M,
  output logic        hash_ready,
  output logic [31:0] digest_final
);

  typedef enum logic [1:0] {IDLE, ABSORB, FINAL} state_t;
  typedef logic [7:0][3:0] hvec_t;

  // h[0] sits in the low nibble here; the digest reorders it to the top
  localparam hvec_t H_INIT = {4'h3, 4'h0, 4'hF, 4'hD,
                              4'h1, 4'h7, 4'hB, 4'h4};

  localparam logic [63:0] S1_R0 = 64'hE4D12FB83A6C5907;
  localparam logic [63:0] S1_R1 = 64'h0F74E2D1A6CB9538;
  localparam logic [63:0] S1_R2 = 64'h41E8D62BFC973A50;
  localparam logic [63:0] S1_R3 = 64'hFC8249175B3EA06D;

  state_t      state;
  hvec_t       h;
  hvec_t       h_src;
  hvec_t       h_abs;
  hvec_t       h_fin;
  logic [63:0] len;
  logic [63:0] cnt;
  logic [63:0] cnt_inc;

  function automatic logic [5:0] compress(input logic [7:0] b);
    return {b[7] ^ b[2], b[6], b[5], b[4] ^ b[1], b[3], b[0]};
  endfunction

  function automatic logic [3:0] sbox1(input logic [5:0] x);
    logic [63:0] row;
    unique case ({x[5], x[0]})
      2'd0:    row = S1_R0;
      2'd1:    row = S1_R1;
      2'd2:    row = S1_R2;
      default: row = S1_R3;
    endcase
    row = row << {x[4:1], 2'b00};
    return row[63:60];
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] x,
                                       input logic [1:0] n);
    logic [3:0] r;
    unique case (n)
      2'd1:    r = {x[2:0], x[3]};
      2'd2:    r = {x[1:0], x[3:2]};
      2'd3:    r = {x[0], x[3:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // In-place update: H[7] already sees the new H[0] of this round
  function automatic hvec_t one_round(input hvec_t hi,
                                      input logic [3:0] s);
    hvec_t ho;
    ho = hi;
    for (int j = 0; j < 8; j++)
      ho[3'(j)] = rotl4(ho[3'(j + 1)] ^ s, 2'(j));
    return ho;
  endfunction

  function automatic hvec_t absorb(input hvec_t hi,
                                   input logic [7:0] b);
    hvec_t      ho;
    logic [3:0] s;
    ho = hi;
    s  = sbox1(compress(b));
    for (int r = 0; r < 32; r++)
      ho = one_round(ho, s);
    return ho;
  endfunction

  function automatic hvec_t finalize(input hvec_t hi,
                                     input logic [63:0] l);
    hvec_t ho;
    ho = hi;
    for (int r = 0; r < 32; r++)
      ho = one_round(ho, sbox1(compress(l[{3'(r), 3'b000} +: 8])));
    return ho;
  endfunction

  always_comb begin
    h_src   = (state == IDLE) ? H_INIT : h;
    h_abs   = absorb(h_src, M);
    h_fin   = finalize(h, len);
    cnt_inc = cnt + 64'd1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      hash_ready   <= 1'b0;
      digest_final <= '0;
      cnt          <= '0;
      len          <= '0;
      h            <= H_INIT;
    end else begin
      unique case (state)
        IDLE: begin
          if (M_valid) begin
            len        <= C_in;
            hash_ready <= 1'b0;
            if (C_in == 64'd0) begin
              h     <= H_INIT;
              cnt   <= '0;
              state <= FINAL;
            end else begin
              h     <= h_abs;
              cnt   <= 64'd1;
              state <= (C_in == 64'd1) ? FINAL : ABSORB;
            end
          end
        end
        ABSORB: begin
          if (M_valid) begin
            h   <= h_abs;
            cnt <= cnt_inc;
            if (cnt_inc == len)
              state <= FINAL;
          end
        end
        FINAL: begin
          digest_final <= {h_fin[0], h_fin[1], h_fin[2], h_fin[3],
                           h_fin[4], h_fin[5], h_fin[6], h_fin[7]};
          hash_ready   <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_hash_des.sv
// Randomized scoreboard bench for full_hash_des.
// Expected digests come from an integer reference model of the hash rules.
module tb_full_hash_des;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        rst_n;
  logic        M_valid;
  logic [63:0] C_in;
  logic [7:0]  M;
  logic        hash_ready;
  logic [31:0] digest_final;

  int tests;
  int fails;
  logic [31:0] expq[$];
  logic prev_rdy;

  int sb[4][16] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
    '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
    '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
    '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
  };

  full_hash_des dut (
    .clk(clk),
    .rst_n(rst_n),
    .M_valid(M_valid),
    .C_in(C_in),
    .M(M),
    .hash_ready(hash_ready),
    .digest_final(digest_final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bitof(int v, int k);
    return (v >> k) & 1;
  endfunction

  function automatic int comp(int m);
    return ((bitof(m, 7) ^ bitof(m, 2)) << 5) | (bitof(m, 6) << 4) |
           (bitof(m, 5) << 3) | ((bitof(m, 4) ^ bitof(m, 1)) << 2) |
           (bitof(m, 3) << 1) | bitof(m, 0);
  endfunction

  function automatic int s1(int x);
    return sb[bitof(x, 5) * 2 + bitof(x, 0)][(x >> 1) & 15];
  endfunction

  function automatic int rotl(int x, int n);
    return ((x << n) | (x >> (4 - n))) & 15;
  endfunction

  function automatic logic [31:0] model(longint unsigned len, bq_t b);
    int h[8];
    int s;
    logic [31:0] d;
    h = '{4, 11, 7, 1, 13, 15, 0, 3};
    for (int i = 0; i < int'(len); i++) begin
      s = s1(comp(int'(b[i])));
      for (int r = 0; r < 32; r++)
        for (int j = 0; j < 8; j++)
          h[j] = rotl(h[(j + 1) % 8] ^ s, j % 4);
    end
    for (int r = 0; r < 32; r++) begin
      s = s1(comp(int'((len >> (8 * (r % 8))) & 64'hFF)));
      for (int j = 0; j < 8; j++)
        h[j] = rotl(h[(j + 1) % 8] ^ s, j % 4);
    end
    d = 0;
    for (int j = 0; j < 8; j++)
      d = (d << 4) | 32'(h[j]);
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(string name, logic [31:0] a, logic [31:0] b);
    tests++;
    if (a === b) begin
      fails++;
      $display("FAIL %s: got %h, expected a value different from %h",
               name, a, b);
    end
  endtask

  always @(negedge clk) begin
    if (hash_ready === 1'b1 && prev_rdy !== 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_digest: got %h, expected none",
                 digest_final);
      end else begin
        chk("digest", {32'h0, digest_final}, {32'h0, expq.pop_front()});
      end
    end
    prev_rdy = hash_ready;
  end

  task automatic send(input longint unsigned len, input bq_t b,
                      input int pause, output logic [31:0] dig);
    int np;
    expq.push_back(model(len, b));
    @(negedge clk);
    M_valid = 1'b1;
    C_in    = len;
    M       = (len > 0) ? b[0] : 8'($urandom);
    for (int i = 1; i < int'(len); i++) begin
      np = (pause < 0) ? int'($urandom_range(0, 2)) : pause;
      for (int p = 0; p < np; p++) begin
        @(negedge clk);
        M_valid = 1'b0;
        M       = 8'($urandom);
        C_in    = {$urandom, $urandom};
      end
      @(negedge clk);
      M_valid = 1'b1;
      M       = b[i];
      C_in    = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("ready_low_in_final", {63'h0, hash_ready}, 64'h0);
    M_valid = 1'b1;
    M       = 8'($urandom);
    C_in    = {$urandom, $urandom} | 64'h2;
    @(negedge clk);
    M_valid = 1'b0;
    chk("ready_latency", {63'h0, hash_ready}, 64'h1);
    dig = digest_final;
  endtask

  initial begin
    bq_t b, e;
    logic [31:0] d_empty, d_empty2, d_a, d156a, d156b, d255, d155, dx;
    int n;
    tests    = 0;
    fails    = 0;
    prev_rdy = 1'b0;
    rst_n    = 1'b1;
    M_valid  = 1'b0;
    C_in     = '0;
    M        = '0;
    #2;
    chk("reset_ready", {63'h0, hash_ready}, 64'h0);
    chk("reset_digest", {32'h0, digest_final}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    e = {};
    send(0, e, 0, d_empty);
    send(0, e, 0, d_empty2);
    chk("empty_repeat", {32'h0, d_empty2}, {32'h0, d_empty});

    b = {8'h41};
    send(1, b, 0, d_a);
    chk_ne("one_byte_vs_empty", d_a, d_empty);

    b = {};
    for (int i = 0; i < 156; i++) b.push_back(8'(i));
    send(156, b, 0, d156a);
    send(156, b, 2, d156b);
    chk("pause_invariance", {32'h0, d156b}, {32'h0, d156a});

    b = {};
    for (int i = 0; i < 255; i++) b.push_back(8'(i));
    send(255, b, 0, d255);
    chk_ne("len255_vs_156", d255, d156a);

    b = {};
    for (int i = 0; i < 155; i++) b.push_back(8'(i));
    send(155, b, 0, d155);
    chk_ne("len155_vs_156", d155, d156a);

    b = {};
    for (int i = 0; i < 400; i++) b.push_back(8'h41);
    send(400, b, 0, dx);

    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 40));
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      send(longint'(n), b, -1, dx);
    end

    @(negedge clk);
    M_valid = 1'b1;
    C_in    = 64'd50;
    M       = 8'($urandom);
    repeat (20) begin
      @(negedge clk);
      M = 8'($urandom);
    end
    #3;
    rst_n = 1'b1;
    #1;
    chk("midreset_ready", {63'h0, hash_ready}, 64'h0);
    chk("midreset_digest", {32'h0, digest_final}, 64'h0);
    M_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;

    send(0, e, 0, dx);
    chk("post_reset_empty", {32'h0, dx}, {32'h0, d_empty});
    b = {8'h41};
    send(1, b, 1, dx);

    repeat (3) @(negedge clk);
    chk("pending_digests", 64'(expq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/full_hash_des.md
FULL_HASH_DES -- requirements
Module: full_hash_des

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL expose: rst_n  input  1  asynchronous reset, active-high despite the name: rst_n=1 clears state immediately, independent of clk.
REQ-003 SHALL expose: M_valid  input  1  M (and, on a message's first cycle, C_in) valid this cycle.
REQ-004 SHALL expose: C_in  input  64  message length in bytes, sampled only on the first valid cycle of a message.
REQ-005 SHALL expose: M  input  8  message byte.
REQ-006 SHALL expose: hash_ready  output  1  digest_final holds the completed digest of the last message.
REQ-007 SHALL expose: digest_final  output  32  registered digest.

Function
REQ-008 SHALL have states IDLE, ABSORB, FINAL, plus a 64-bit length register LEN, a 64-bit byte counter CNT and an 8x4-bit chaining state H[0..7].
REQ-009 SHALL initialise H to nibbles 4,B,7,1,D,F,0,3 (H[0]..H[7]) on reset and on every message start.
REQ-010 In IDLE with M_valid=1 SHALL latch LEN=C_in, clear hash_ready, reinitialise H, and then act on C_in:
- C_in=0: ignore M; go to FINAL.
- otherwise: absorb M; set CNT=1; go to FINAL if C_in=1, else ABSORB.
REQ-011 In ABSORB SHALL absorb M when M_valid=1 and increment CNT; when the incremented CNT equals LEN SHALL go to FINAL; M_valid=0 cycles (pauses of any length) SHALL change nothing.
REQ-012 Absorbing SHALL take exactly one clock per byte, so back-to-back bytes are accepted every cycle; C_in changes after the first cycle SHALL be ignored.
REQ-013 Byte absorption SHALL first form M6 = {M[7]^M[2], M[6], M[5], M[4]^M[1], M[3], M[0]}.
REQ-014 Byte absorption SHALL then do 32 rounds, each for j=0..7 in order: H[j] = rotl4(H[(j+1) mod 8] XOR S1(M6), j mod 4), using already-updated values within the round.
- S1 = DES S-box 1 per FIPS 46-3: row = {b5,b0}, column = b4..b1.
- rotl4 = 4-bit rotate left.
REQ-015 FINAL SHALL take one cycle and run 32 rounds with the same round form, where round r uses byte k = r mod 8 of LEN (LEN[8k+7:8k]) compressed to 6 bits as in REQ-013.
REQ-016 FINAL SHALL register digest_final = {H[0],H[1],...,H[7]} (H[0] in bits 31:28), set hash_ready=1 and return to IDLE.
REQ-017 hash_ready and digest_final SHALL hold until the first valid cycle of the next message; digest_final SHALL keep its old value until overwritten.
REQ-018 M_valid during FINAL SHALL be ignored.
REQ-019 Latency: the digest SHALL be visible one clock after the edge that accepts the last byte (or the C_in=0 start).
REQ-020 The digest SHALL be deterministic: identical byte sequences with identical lengths give identical digests, independent of pause pattern.

Reset
REQ-021 rst_n=1 SHALL asynchronously force: state=IDLE, hash_ready=0, digest_final=32'h0, CNT=0, LEN=0, H=initial nibbles.
REQ-022 Reset mid-message SHALL abort the message with no digest produced; the first M_valid after release starts a new message.

Verification
REQ-023 Reset, then one cycle M_valid=1 with C_in=0 -> after the next edge hash_ready=1; the digest is stable, repeatable and equal to the golden-model value.
REQ-024 C_in=1, M=8'h41 for one cycle -> hash_ready=1 one edge later; the digest differs from the empty digest.
REQ-025 C_in=156, bytes 0..155 back-to-back; then the same bytes each followed by two idle cycles -> both digests equal.
REQ-026 C_in=255, bytes 0..254 -> the digest differs from the 156-byte digest; C_in=155 with bytes 0..154 also differs.
REQ-027 C_in=400, M=8'h41 held with M_valid continuous -> exactly 400 bytes absorbed, then hash_ready=1 one edge later.
REQ-028 Assert rst_n mid-message and between clock edges -> outputs clear immediately, hash_ready=0, digest_final=0; the next message hashes as if from power-up.
